wshb_mire_gen: RTL

// Test-pattern ("mire") Wishbone master. It writes a grid pattern into the frame buffer in SDRAM.

---
 rtl/wshb_mire_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/wshb_mire_gen.sv
// wshb_mire_gen: Wishbone master painting a white grid test pattern into the SDRAM frame buffer,
// writing bursts of at most BURST_LEN words and dropping cyc for YIELD_CYC cycles between bursts.
module wshb_mire_gen #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          BURST_LEN = 64,
  parameter int          YIELD_CYC = 2,
  parameter int          GRID      = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic [31:0] dat_ms_o,
  input  logic        ack_i,
  output logic        frame_done_o
);
  localparam int XW  = $clog2(HDISP + 1);
  localparam int YW  = $clog2(VDISP + 1);
  localparam int CW  = $clog2(BURST_LEN + 1);
  localparam int YCW = $clog2(YIELD_CYC + 1);
  typedef enum logic [1:0] {IDLE, WRITE, YIELD} state_t;
  state_t          state_q;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q;
  logic [YCW-1:0]  ycnt_q;
  logic            last_x, last_pix, burst_end;
  assign stb_o = cyc_o;
  assign we_o  = 1'b1;
  assign sel_o = 4'hF;
  assign cti_o = 3'b000;
  assign bte_o = 2'b00;
  function automatic logic [31:0] pixel(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return ((px & XW'(GRID - 1)) == '0 || (py & YW'(GRID - 1)) == '0 ||
            px == XW'(HDISP - 1) || py == YW'(VDISP - 1)) ? 32'h00FF_FFFF : 32'h0;
  endfunction
  always_comb begin
    last_x    = x_q == XW'(HDISP - 1);
    last_pix  = last_x && y_q == YW'(VDISP - 1);
    x_d       = last_x ? '0 : x_q + 1'b1;
    y_d       = last_x ? (last_pix ? '0 : y_q + 1'b1) : y_q;
    burst_end = cnt_q == CW'(BURST_LEN - 1) || last_pix;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cyc_o        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      ycnt_q       <= '0;
      adr_o        <= BASE_ADDR;
      dat_ms_o     <= 32'h00FF_FFFF;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state_q)
        IDLE: if (enable_i) begin
          state_q <= WRITE;
          cyc_o   <= 1'b1;
        end
        WRITE: if (ack_i) begin
          // next word goes out on the same edge that retires the current one
          x_q          <= x_d;
          y_q          <= y_d;
          adr_o        <= last_pix ? BASE_ADDR : adr_o + 32'd4;
          dat_ms_o     <= pixel(x_d, y_d);
          cnt_q        <= burst_end ? '0 : cnt_q + 1'b1;
          frame_done_o <= last_pix;
          if (burst_end) begin
            state_q <= YIELD;
            cyc_o   <= 1'b0;
            ycnt_q  <= '0;
          end
        end
        default: if (ycnt_q == YCW'(YIELD_CYC - 1)) begin
          state_q <= enable_i ? WRITE : IDLE;
          cyc_o   <= enable_i;
        end else ycnt_q <= ycnt_q + 1'b1;
      endcase
    end
  end
endmodule
